// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: MD op codes, default latencies, op-class helpers (MDU_MADD_EN enables MADD/MADDU)
package mdu_unit_pkg;
   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;
   localparam logic [3:0] MD_MADD  = 4'd9;
   localparam logic [3:0] MD_MADDU = 4'd10;
   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   function automatic logic md_long(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU};
`else
      return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`endif
   endfunction

   function automatic logic md_div(input logic [3:0] op);
      return op == MD_DIV || op == MD_DIVU;
   endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational 64-bit {HI,LO} result of an MD op; divide-by-zero returns HI/LO unchanged
module mdu_calc
   import mdu_unit_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [63:0] res
);
   logic [63:0] ps, pu;
   logic [31:0] a, b, bd, uq, ur, q, r;
   logic        sgn, bz;
   assign ps  = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign pu  = {32'b0, rs} * {32'b0, rt};
   // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with zero remainder
   assign sgn = op == MD_DIV;
   assign a   = (sgn & rs[31]) ? -rs : rs;
   assign b   = (sgn & rt[31]) ? -rt : rt;
   assign bz  = rt == '0;
   assign bd  = bz ? 32'd1 : b;
   assign uq  = a / bd;
   assign ur  = a % bd;
   assign q   = (sgn & (rs[31] ^ rt[31])) ? -uq : uq;
   assign r   = (sgn & rs[31]) ? -ur : ur;
   assign res = op == MD_MULT  ? ps :
                op == MD_MULTU ? pu :
                md_div(op)     ? (bz ? {hi, lo} : {r, q}) :
                op == MD_MADD  ? {hi, lo} + ps :
                op == MD_MADDU ? {hi, lo} + pu :
                op == MD_MTHI  ? {rs, lo} :
                op == MD_MTLO  ? {hi, rs} : {hi, lo};
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit with fixed-latency HI/LO commit and busy stall (MDU_MADD_EN adds MADD/MADDU)
module mdu_unit
   import mdu_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic        req,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out,
   output logic [31:0] md_result
);
   localparam int CW = $clog2((DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES) + 1);
   logic [CW-1:0] count;
   logic [31:0]   hi, lo, hi_tmp, lo_tmp;
   logic [63:0]   res;
   logic          go, long_op, mt_op, run;
   mdu_calc u_calc (
      .op  (md_op),
      .rs  (rs_data),
      .rt  (rt_data),
      .hi  (hi),
      .lo  (lo),
      .res (res)
   );
   assign run       = count != '0;
   assign go        = start & ~req & ~run;
   assign long_op   = md_long(md_op);
   assign mt_op     = md_op == MD_MTHI || md_op == MD_MTLO;
   assign busy      = (go & (long_op | mt_op)) | run;
   assign hi_out    = hi;
   assign lo_out    = lo;
   assign md_result = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : '0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         hi_tmp <= '0;
         lo_tmp <= '0;
      end else if (go & long_op) begin
         {hi_tmp, lo_tmp} <= res;
         count            <= md_div(md_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (go & mt_op) begin
         {hi, lo} <= res;
      end else if (run) begin
         count <= count - CW'(1);
         if (count == CW'(1)) {hi, lo} <= {hi_tmp, lo_tmp};
      end
   end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit (MADD checks follow MDU_MADD_EN)
module tb_mdu_unit;
   import mdu_unit_pkg::*;
   logic        clk = 0, reset = 0, start = 0, req = 0, busy;
   logic [3:0]  md_op = MD_NONE;
   logic [31:0] rs_data = '0, rt_data = '0, hi_out, lo_out, md_result;
   int          total = 0, bad = 0;

   mdu_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .req       (req),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .busy      (busy),
      .hi_out    (hi_out),
      .lo_out    (lo_out),
      .md_result (md_result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called 1ns after an edge; returns at the first busy-low cycle, 5ns past its edge.
   task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int n, input logic [31:0] ph, input logic [31:0] pl);
      start = 1; md_op = op; rs_data = a; rt_data = b;
      for (int i = 0; i <= n; i++) begin
         #4;
         chk("busy_run", 32'(busy), 1);
         chk("hold_hi", hi_out, ph);
         chk("hold_lo", lo_out, pl);
         cyc();
         start = 0; md_op = MD_NONE;
      end
      #4;
      chk("busy_done", 32'(busy), 0);
   endtask

   initial begin
      cyc(); cyc();
      reset = 1;
      #4;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_hi", hi_out, 0);
      chk("rst_lo", lo_out, 0);
      chk("rst_mdres", md_result, 0);
      cyc();

      run(MD_MULT, 32'hFFFFFFFE, 32'd3, MD_MULT_CYCLES, 0, 0);
      chk("mult_hi", hi_out, 32'hFFFFFFFF);
      chk("mult_lo", lo_out, 32'hFFFFFFFA);
      cyc();
      run(MD_MULTU, 32'hFFFFFFFE, 32'd3, MD_MULT_CYCLES, 32'hFFFFFFFF, 32'hFFFFFFFA);
      chk("multu_hi", hi_out, 32'h2);
      chk("multu_lo", lo_out, 32'hFFFFFFFA);
      cyc();
      run(MD_DIV, 32'hFFFFFFF9, 32'd2, MD_DIV_CYCLES, 32'h2, 32'hFFFFFFFA);
      chk("div_hi", hi_out, 32'hFFFFFFFF);
      chk("div_lo", lo_out, 32'hFFFFFFFD);
      cyc();
      run(MD_DIVU, 32'd7, 32'd0, MD_DIV_CYCLES, 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk("div0_hi", hi_out, 32'hFFFFFFFF);
      chk("div0_lo", lo_out, 32'hFFFFFFFD);
      cyc();
      run(MD_DIV, 32'h80000000, 32'hFFFFFFFF, MD_DIV_CYCLES, 32'hFFFFFFFF, 32'hFFFFFFFD);
      chk("ovf_hi", hi_out, 32'h0);
      chk("ovf_lo", lo_out, 32'h80000000);
      cyc();

      run(MD_MTHI, 32'hABCD, 32'd0, 0, 32'h0, 32'h80000000);
      chk("mthi_hi", hi_out, 32'hABCD);
      cyc();
      run(MD_MTLO, 32'h1234, 32'd0, 0, 32'hABCD, 32'h80000000);
      chk("mtlo_lo", lo_out, 32'h1234);
      chk("mtlo_hi", hi_out, 32'hABCD);
      cyc();
      md_op = MD_MFLO; #4; chk("mflo", md_result, 32'h1234);
      cyc();
      md_op = MD_MFHI; #4; chk("mfhi", md_result, 32'hABCD);
      cyc();
      md_op = 4'd13; #4; chk("mf_none", md_result, 0);
      cyc();

      start = 1; req = 1; md_op = MD_MULT; rs_data = 32'd3; rt_data = 32'd3;
      #4; chk("req_busy", 32'(busy), 0);
      cyc();
      start = 0; req = 0; md_op = MD_NONE;
      for (int i = 0; i < 7; i++) cyc();
      #4;
      chk("req_busy2", 32'(busy), 0);
      chk("req_hi", hi_out, 32'hABCD);
      chk("req_lo", lo_out, 32'h1234);
      cyc();

      start = 1; md_op = MD_DIV; rs_data = 32'd100; rt_data = 32'd7;
      cyc();
      start = 0; md_op = MD_NONE;
      cyc();
      start = 1; md_op = MD_MULT; rs_data = 32'd2; rt_data = 32'd2;
      #4; chk("ign_busy", 32'(busy), 1);
      cyc();
      start = 0; md_op = MD_NONE;
      for (int i = 3; i <= MD_DIV_CYCLES; i++) begin
         #4; chk("ign_hold_lo", lo_out, 32'h1234);
         cyc();
      end
      #4;
      chk("ign_busy_done", 32'(busy), 0);
      chk("ign_hi", hi_out, 32'd2);
      chk("ign_lo", lo_out, 32'd14);
      cyc();

      start = 1; md_op = MD_DIV; rs_data = 32'd9; rt_data = 32'd2;
      cyc();
      start = 0; md_op = MD_NONE;
      cyc(); cyc();
      reset = 0;
      cyc();
      reset = 1;
      #4;
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_hi", hi_out, 0);
      chk("mrst_lo", lo_out, 0);
      for (int i = 0; i < 12; i++) cyc();
      #4;
      chk("mrst_late_lo", lo_out, 0);
      chk("mrst_late_hi", hi_out, 0);
      cyc();

      run(MD_MTLO, 32'd5, 32'd0, 0, 0, 0);
      cyc();
`ifdef MDU_MADD_EN
      run(MD_MADD, 32'd2, 32'd3, MD_MULT_CYCLES, 0, 5);
      chk("madd_lo", lo_out, 32'd11);
      chk("madd_hi", hi_out, 32'd0);
      cyc();
`else
      start = 1; md_op = MD_MADD; rs_data = 32'd2; rt_data = 32'd3;
      #4; chk("madd_off_busy", 32'(busy), 0);
      cyc();
      start = 0; md_op = MD_NONE;
      for (int i = 0; i < 7; i++) cyc();
      #4;
      chk("madd_off_lo", lo_out, 32'd5);
      chk("madd_off_hi", hi_out, 32'd0);
      cyc();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
